nios_system_sine_streamer: RTL and testbench
============================================

# nios_system_sine_streamer

Sequencer that sits directly in front of the 1024×32 sine ROM block. It drives the ROM address using a phase accumulator (DDS-style) and captures the ROM read data. It then streams a packet of samples out on an Avalon-ST source with backpressure. Software sets the step, offset and length, then pulses `start`.

## Interface
- `ADDR_W`, 10: ROM address width; the address is `phase[31:32-ADDR_W]`.
- `DATA_W`, 32: sample width.
- `FIFO_DEPTH`, 4: output buffer depth. Must be ≥4 to hold the issue credit below.

Ports:
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse; honoured only in IDLE.
- `phase_inc`  in  32  phase step per sample; sampled on an accepted `start`.
- `phase_offset`  in  32  initial phase; sampled on an accepted `start`.
- `num_samples`  in  16  packet length; sampled on an accepted `start`.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse when a packet has fully left the block.
- `rom_address`  out  ADDR_W  registered ROM address.
- `rom_chipselect`  out  1  high in the cycle a read is issued.
- `rom_clken`  out  1  constant 1.
- `rom_readdata`  in  DATA_W  ROM q. Valid one cycle after the address is presented (address registered, output unregistered).
- `src_data`  out  DATA_W  sample.
- `src_valid`  out  1  sample valid.
- `src_ready`  in  1  sink accepts when high together with `src_valid`.
- `src_startofpacket`  out  1  marks the first sample.
- `src_endofpacket`  out  1  marks sample number `num_samples`.

## Operation
- **FSM states:** IDLE, RUN, DRAIN.
- **IDLE → RUN:** `start`=1 and `num_samples`≠0.
  - Latch `phase_inc`, `num_samples`, and phase←`phase_offset`.
  - Clear the issued counter.
- **IDLE, `start` with `num_samples`=0:** ignored; no `done`, stays IDLE.
- **RUN, issue rule:** issue one read per cycle while `fifo_count + inflight ≤ FIFO_DEPTH-2`. Both terms are registered values; a same-cycle pop is not credited.
- **RUN, on issue:**
  - `rom_address`←`phase[31:22]`, `rom_chipselect`=1.
  - phase←phase+`phase_inc`, modulo 2^32 (wraps silently).
  - issued←issued+1.
- **RUN → DRAIN:** on the issue that makes issued == `num_samples`.
- **In-flight tag:** each issue carries a 1-cycle tag `{valid, sop, eop}`.
  - sop: issued==0.
  - eop: issued==`num_samples`-1.
- **Capture:** the cycle after issue, `rom_readdata` and its tag are written into the FIFO.
- **DRAIN → IDLE:** when the FIFO is empty and nothing is in flight. `done` pulses in that same transition cycle.
- **`start` in RUN or DRAIN:** ignored; latched parameters are not changed.
- **FIFO:**
  - Head drives `src_data`, `src_startofpacket`, `src_endofpacket`.
  - `src_valid` = FIFO not empty.
  - Pop on `src_valid & src_ready`.
  - Simultaneous push and pop: count unchanged.
  - Overflow cannot occur by the credit rule; this is checked by an assertion in simulation.
- **Output holding:** `src_data` and the packet flags stay stable while `src_valid` & !`src_ready`.
- **Reset (also mid-packet):** state IDLE, FIFO flushed, in-flight cleared, phase and counters 0. The current packet is abandoned with no `done` and no `src_endofpacket`.
- **Output reset values:** all outputs 0 except `rom_clken`=1.

## Timing
- Cycle 0: `start` accepted.
- Cycle 1: first address is on `rom_address`.
- Cycle 2: data captured into the FIFO.
- Cycle 3: first `src_valid`=1. Start-to-first-sample latency is 3 cycles.
- With `src_ready` held high, throughput is 1 sample/clock. The last sample is presented at cycle `num_samples`+2.
- `done` rises the cycle after the last pop.
- While `src_ready`=0, at most 1 further read issues after the FIFO holds `FIFO_DEPTH-2` entries; the FIFO peaks at `FIFO_DEPTH-1`.
- `busy` rises the cycle after `start` and falls in the same cycle `done` pulses.

## Test plan
- **Basic packet.** Stimulus: ROM loaded with ROM[i]=i; `phase_offset`=0, `phase_inc`=0x0040_0000, `num_samples`=4, `src_ready`=1.
  - Response: addresses 0,1,2,3 on cycles 1–4.
  - Data 0,1,2,3 on cycles 3–6, with sop on the first sample and eop on the fourth.
  - `done` on cycle 7.
- **Phase wrap.** Stimulus: `phase_offset`=0xFFC0_0000, `phase_inc`=0x0040_0000, `num_samples`=3.
  - Response: addresses 1023, 0, 1; data ROM[1023], ROM[0], ROM[1].
- **Fractional step.** Stimulus: `phase_inc`=0x0020_0000, `num_samples`=4.
  - Response: addresses 0,0,1,1.
- **Backpressure.** Stimulus: `num_samples`=8; `src_ready` low on cycles 4–10, otherwise high.
  - Response: all 8 samples in order; no overflow assertion; `fifo_count` peaks at 3.
  - Data held stable while stalled; `done` once.
- **Ignored starts.**
  - `start` during RUN with different parameters: the packet is unaffected.
  - `start` with `num_samples`=0 in IDLE: no activity and no `done`.
- **Reset mid-packet.** Stimulus: `reset` at cycle 4 of a 16-sample packet, then a new 2-sample `start`.
  - Response: all outputs 0 the cycle after reset.
  - The next packet carries exactly 2 samples with correct sop/eop; no stale data.

Source files
------------

// File: rtl/nios_system_sine_streamer.sv
// DDS-style sequencer in front of the sine ROM: steps a phase accumulator, reads the ROM
// and streams a packet of samples out on an Avalon-ST source through a small FIFO.
module nios_system_sine_streamer #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       phase_inc,
    input  logic [31:0]       phase_offset,
    input  logic [15:0]       num_samples,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_chipselect,
    output logic              rom_clken,
    input  logic [DATA_W-1:0] rom_readdata,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_startofpacket,
    output logic              src_endofpacket
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W:0]   CREDIT = (CNT_W+1)'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [31:0]       phase_q, phase_d;
    logic [31:0]       inc_q, inc_d;
    logic [15:0]       num_q, num_d;
    logic [15:0]       issued_q, issued_d;
    logic              tag_valid_q, tag_valid_d;
    logic              tag_sop_q, tag_sop_d;
    logic              tag_eop_q, tag_eop_d;

    logic [DATA_W+1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W:0]    occupancy;
    logic [DATA_W+1:0] head;
    logic              issue, push, pop, fifo_empty;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit uses registered occupancy only, so one slot stays free for the read in flight.
    assign occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, tag_valid_q};
    assign fifo_empty = (count_q == '0);
    assign push       = tag_valid_q;
    assign pop        = !fifo_empty && src_ready;
    assign head       = fifo_mem_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        inc_d       = inc_q;
        num_d       = num_q;
        issued_d    = issued_q;
        tag_valid_d = 1'b0;
        tag_sop_d   = 1'b0;
        tag_eop_d   = 1'b0;
        issue       = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && num_samples != 16'd0) begin
                    state_d  = RUN;
                    phase_d  = phase_offset;
                    inc_d    = phase_inc;
                    num_d    = num_samples;
                    issued_d = 16'd0;
                end
            end
            RUN: begin
                if (occupancy <= CREDIT) begin
                    issue       = 1'b1;
                    phase_d     = phase_q + inc_q;
                    issued_d    = issued_q + 16'd1;
                    tag_valid_d = 1'b1;
                    tag_sop_d   = (issued_q == 16'd0);
                    tag_eop_d   = (issued_q == num_q - 16'd1);
                    if (issued_q == num_q - 16'd1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty && !tag_valid_q) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= '0;
            inc_q       <= '0;
            num_q       <= '0;
            issued_q    <= '0;
            tag_valid_q <= 1'b0;
            tag_sop_q   <= 1'b0;
            tag_eop_q   <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            inc_q       <= inc_d;
            num_q       <= num_d;
            issued_q    <= issued_d;
            tag_valid_q <= tag_valid_d;
            tag_sop_q   <= tag_sop_d;
            tag_eop_q   <= tag_eop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {tag_sop_q, tag_eop_q, rom_readdata};
        end
        if (!reset) begin
            assert (!(push && !pop && count_q == FULL));
        end
    end

    assign busy              = (state_q != IDLE) && !done;
    assign rom_address       = phase_q[31 -: ADDR_W];
    assign rom_chipselect    = issue;
    assign rom_clken         = 1'b1;
    assign src_valid         = !fifo_empty;
    assign src_data          = src_valid ? head[DATA_W-1:0] : '0;
    assign src_startofpacket = src_valid && head[DATA_W+1];
    assign src_endofpacket   = src_valid && head[DATA_W];
endmodule

// File: tb/tb_nios_system_sine_streamer.sv
// Self-checking bench for nios_system_sine_streamer: ROM model, stream monitor and
// an address/sample reference computed directly from offset + k*step.
module tb_nios_system_sine_streamer;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] phase_inc;
    logic [31:0] phase_offset;
    logic [15:0] num_samples;
    logic        busy;
    logic        done;
    logic [9:0]  rom_address;
    logic        rom_chipselect;
    logic        rom_clken;
    logic [31:0] rom_readdata;
    logic [31:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic        src_startofpacket;
    logic        src_endofpacket;

    nios_system_sine_streamer dut (
        .clk(clk), .reset(reset), .start(start),
        .phase_inc(phase_inc), .phase_offset(phase_offset), .num_samples(num_samples),
        .busy(busy), .done(done),
        .rom_address(rom_address), .rom_chipselect(rom_chipselect), .rom_clken(rom_clken),
        .rom_readdata(rom_readdata),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .src_startofpacket(src_startofpacket), .src_endofpacket(src_endofpacket)
    );

    always #5 clk = ~clk;

    logic [31:0] romMem [1024];
    always @(posedge clk) rom_readdata <= romMem[rom_address];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    int stallLo = 100, stallHi = -1;
    bit randReady = 0;
    int injectCyc = -100;

    logic [9:0]  issAddr[$];
    int          issCyc[$];
    logic [31:0] beatData[$];
    bit          beatSop[$];
    bit          beatEop[$];
    int          beatCyc[$];
    int          doneCnt, doneCyc, busyRise;
    bit          doneBusy;
    int          stallViolations;
    bit          prevStall = 0, prevBusy = 0, prevSop, prevEop;
    logic [31:0] prevData;

    // Monitor: samples mid-cycle and logs issues, accepted beats and done pulses by cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            if (rom_chipselect) begin
                issAddr.push_back(rom_address);
                issCyc.push_back(cyc - t0);
            end
            if (src_valid && src_ready) begin
                beatData.push_back(src_data);
                beatSop.push_back(src_startofpacket);
                beatEop.push_back(src_endofpacket);
                beatCyc.push_back(cyc - t0);
            end
            if (done) begin
                doneCnt = doneCnt + 1;
                doneCyc = cyc - t0;
                doneBusy = busy;
            end
            if (prevStall && !(src_valid && src_data === prevData &&
                               src_startofpacket === prevSop && src_endofpacket === prevEop))
                stallViolations = stallViolations + 1;
            if (busy && !prevBusy) busyRise = cyc - t0;
        end
        prevStall = !reset && src_valid && !src_ready;
        prevData  = src_data;
        prevSop   = src_startofpacket;
        prevEop   = src_endofpacket;
        prevBusy  = busy;
    end

    function automatic logic [9:0] expAddr(input logic [31:0] off, input logic [31:0] inc, input int k);
        logic [31:0] p;
        p = off + inc * 32'(k);
        return p[31:22];
    endfunction

    function automatic bit readyFor(input int rel);
        if (randReady) return ($urandom_range(0, 1) == 1);
        return !(rel >= stallLo && rel <= stallHi);
    endfunction

    task automatic step();
        int rel;
        @(posedge clk); #1;
        rel = cyc + 1 - t0;
        start = 1'b0;
        if (rel == injectCyc) begin
            start = 1'b1;
            phase_offset = 32'h1234_5678;
            phase_inc = 32'h0300_0000;
            num_samples = 16'd3;
        end
        src_ready = readyFor(rel);
    endtask

    task automatic start_packet(input logic [31:0] off, input logic [31:0] inc, input logic [15:0] n);
        @(posedge clk); #1;
        t0 = cyc + 1;
        issAddr.delete(); issCyc.delete();
        beatData.delete(); beatSop.delete(); beatEop.delete(); beatCyc.delete();
        doneCnt = 0; doneCyc = -1; busyRise = -1; doneBusy = 1'b1; stallViolations = 0;
        phase_offset = off;
        phase_inc = inc;
        num_samples = n;
        start = 1'b1;
        src_ready = readyFor(0);
    endtask

    task automatic wait_done(input int budget, output bit timedOut);
        timedOut = 1'b1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (doneCnt > 0) begin
                timedOut = 1'b0;
                break;
            end
        end
        repeat (4) step();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; src_ready = 1'b0;
        phase_inc = '0; phase_offset = '0; num_samples = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, rom_chipselect, src_valid, src_startofpacket, src_endofpacket} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b exp=000000",
                     {busy, done, rom_chipselect, src_valid, src_startofpacket, src_endofpacket});
        end
        checks++;
        if (rom_address !== 10'd0 || src_data !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_buses addr=%0d data=%h exp=0/0", rom_address, src_data);
        end
        checks++;
        if (rom_clken !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_clken got=%b exp=1", rom_clken);
        end
    endtask

    task automatic test_basic();
        bit to;
        for (int i = 0; i < 1024; i++) romMem[i] = 32'(i);
        start_packet(32'h0, 32'h0040_0000, 16'd4);
        wait_done(60, to);
        checks++;
        if (to || doneCnt != 1 || doneCyc != 7) begin
            failures++;
            $display("[TB] FAIL basic_done count=%0d cycle=%0d exp=1/7", doneCnt, doneCyc);
        end
        checks++;
        if (issAddr.size() != 4 || beatData.size() != 4) begin
            failures++;
            $display("[TB] FAIL basic_sizes issues=%0d beats=%0d exp=4/4", issAddr.size(), beatData.size());
        end
        for (int k = 0; k < 4 && k < int'(issAddr.size()) && k < int'(beatData.size()); k++) begin
            checks++;
            if (issAddr[k] !== 10'(k) || issCyc[k] != k + 1 || beatData[k] !== 32'(k) ||
                beatCyc[k] != k + 3 || beatSop[k] !== (k == 0) || beatEop[k] !== (k == 3)) begin
                failures++;
                $display("[TB] FAIL basic_sample%0d addr=%0d@%0d data=%0d@%0d sop=%b eop=%b exp addr=%0d@%0d data=%0d@%0d",
                         k, issAddr[k], issCyc[k], beatData[k], beatCyc[k], beatSop[k], beatEop[k],
                         k, k + 1, k, k + 3);
            end
        end
        checks++;
        if (busyRise != 1 || doneBusy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_busy rise=%0d busy_at_done=%b exp=1/0", busyRise, doneBusy);
        end
    endtask

    task automatic test_phase_wrap();
        bit to;
        logic [9:0] want [3];
        want[0] = 10'd1023; want[1] = 10'd0; want[2] = 10'd1;
        for (int i = 0; i < 1024; i++) romMem[i] = $urandom;
        start_packet(32'hFFC0_0000, 32'h0040_0000, 16'd3);
        wait_done(60, to);
        checks++;
        if (to || beatData.size() != 3 || issAddr.size() != 3) begin
            failures++;
            $display("[TB] FAIL wrap_count beats=%0d issues=%0d exp=3/3", beatData.size(), issAddr.size());
        end
        for (int k = 0; k < 3 && k < int'(beatData.size()) && k < int'(issAddr.size()); k++) begin
            checks++;
            if (issAddr[k] !== want[k] || beatData[k] !== romMem[want[k]]) begin
                failures++;
                $display("[TB] FAIL wrap_sample%0d addr=%0d data=%h exp=%0d/%h",
                         k, issAddr[k], beatData[k], want[k], romMem[want[k]]);
            end
        end
    endtask

    task automatic test_fractional();
        bit to;
        logic [9:0] want [4];
        want[0] = 10'd0; want[1] = 10'd0; want[2] = 10'd1; want[3] = 10'd1;
        start_packet(32'h0, 32'h0020_0000, 16'd4);
        wait_done(60, to);
        checks++;
        if (to || issAddr.size() != 4) begin
            failures++;
            $display("[TB] FAIL frac_count issues=%0d exp=4", issAddr.size());
        end
        for (int k = 0; k < 4 && k < int'(issAddr.size()) && k < int'(beatData.size()); k++) begin
            checks++;
            if (issAddr[k] !== want[k] || beatData[k] !== romMem[want[k]]) begin
                failures++;
                $display("[TB] FAIL frac_sample%0d addr=%0d data=%h exp=%0d/%h",
                         k, issAddr[k], beatData[k], want[k], romMem[want[k]]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int early;
        logic [9:0] a;
        stallLo = 4; stallHi = 10;
        start_packet(32'h0, 32'h0040_0000, 16'd8);
        wait_done(100, to);
        stallLo = 100; stallHi = -1;
        early = 0;
        foreach (issCyc[i]) if (issCyc[i] <= 10) early++;
        checks++;
        if (early != 4) begin
            failures++;
            $display("[TB] FAIL bp_credit issues_by_c10=%0d exp=4", early);
        end
        checks++;
        if (to || doneCnt != 1 || beatData.size() != 8) begin
            failures++;
            $display("[TB] FAIL bp_done done=%0d beats=%0d exp=1/8", doneCnt, beatData.size());
        end
        checks++;
        if (stallViolations != 0) begin
            failures++;
            $display("[TB] FAIL bp_hold violations=%0d exp=0", stallViolations);
        end
        for (int k = 0; k < int'(beatData.size()) && k < 8; k++) begin
            a = expAddr(32'h0, 32'h0040_0000, k);
            checks++;
            if (beatData[k] !== romMem[a] || beatSop[k] !== (k == 0) || beatEop[k] !== (k == 7)) begin
                failures++;
                $display("[TB] FAIL bp_sample%0d data=%h sop=%b eop=%b exp=%h", k, beatData[k],
                         beatSop[k], beatEop[k], romMem[a]);
            end
        end
    endtask

    task automatic test_ignored_starts();
        bit to;
        logic [9:0] a;
        injectCyc = 2;
        start_packet(32'h0A00_0000, 32'h0110_0000, 16'd6);
        wait_done(80, to);
        injectCyc = -100;
        checks++;
        if (to || doneCnt != 1 || beatData.size() != 6 || issAddr.size() != 6) begin
            failures++;
            $display("[TB] FAIL ign_run done=%0d beats=%0d issues=%0d exp=1/6/6",
                     doneCnt, beatData.size(), issAddr.size());
        end
        for (int k = 0; k < int'(beatData.size()) && k < 6; k++) begin
            a = expAddr(32'h0A00_0000, 32'h0110_0000, k);
            checks++;
            if (beatData[k] !== romMem[a] || beatEop[k] !== (k == 5)) begin
                failures++;
                $display("[TB] FAIL ign_sample%0d data=%h eop=%b exp=%h", k, beatData[k], beatEop[k], romMem[a]);
            end
        end
        start_packet(32'h0, 32'h0040_0000, 16'd0);
        repeat (10) step();
        checks++;
        if (issAddr.size() != 0 || beatData.size() != 0 || doneCnt != 0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ign_zero issues=%0d beats=%0d done=%0d busy=%b exp=0/0/0/0",
                     issAddr.size(), beatData.size(), doneCnt, busy);
        end
    endtask

    task automatic test_reset_mid();
        bit to, anyEop;
        logic [31:0] off, inc;
        logic [9:0] a;
        start_packet(32'h0, 32'h0040_0000, 16'd16);
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, rom_chipselect, src_valid, src_startofpacket, src_endofpacket} !== 6'b0 ||
            rom_address !== 10'd0 || src_data !== 32'd0 || rom_clken !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rmid_outputs flags=%b addr=%0d data=%h clken=%b exp=000000/0/0/1",
                     {busy, done, rom_chipselect, src_valid, src_startofpacket, src_endofpacket},
                     rom_address, src_data, rom_clken);
        end
        anyEop = 0;
        foreach (beatEop[i]) if (beatEop[i]) anyEop = 1;
        checks++;
        if (doneCnt != 0 || anyEop) begin
            failures++;
            $display("[TB] FAIL rmid_abandon done=%0d eop_seen=%b exp=0/0", doneCnt, anyEop);
        end
        off = $urandom; inc = $urandom;
        start_packet(off, inc, 16'd2);
        wait_done(60, to);
        checks++;
        if (to || doneCnt != 1 || beatData.size() != 2) begin
            failures++;
            $display("[TB] FAIL rmid_next done=%0d beats=%0d exp=1/2", doneCnt, beatData.size());
        end
        for (int k = 0; k < int'(beatData.size()) && k < 2; k++) begin
            a = expAddr(off, inc, k);
            checks++;
            if (beatData[k] !== romMem[a] || beatSop[k] !== (k == 0) || beatEop[k] !== (k == 1)) begin
                failures++;
                $display("[TB] FAIL rmid_sample%0d data=%h sop=%b eop=%b exp=%h", k, beatData[k],
                         beatSop[k], beatEop[k], romMem[a]);
            end
        end
    endtask

    task automatic test_random();
        bit to;
        logic [31:0] off, inc;
        logic [15:0] n;
        logic [9:0] a;
        randReady = 1;
        for (int p = 0; p < 6; p++) begin
            off = $urandom; inc = $urandom;
            n = 16'($urandom_range(1, 20));
            start_packet(off, inc, n);
            wait_done(int'(n) * 40 + 50, to);
            checks++;
            if (to || doneCnt != 1 || beatData.size() != int'(n) || stallViolations != 0) begin
                failures++;
                $display("[TB] FAIL rand%0d_stream done=%0d beats=%0d holdviol=%0d exp=1/%0d/0",
                         p, doneCnt, beatData.size(), stallViolations, n);
            end
            for (int k = 0; k < int'(beatData.size()) && k < int'(n); k++) begin
                a = expAddr(off, inc, k);
                checks++;
                if (beatData[k] !== romMem[a] || beatSop[k] !== (k == 0) || beatEop[k] !== (k == int'(n) - 1)) begin
                    failures++;
                    $display("[TB] FAIL rand%0d_sample%0d data=%h sop=%b eop=%b exp=%h",
                             p, k, beatData[k], beatSop[k], beatEop[k], romMem[a]);
                end
            end
        end
        randReady = 0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) romMem[i] = 32'(i);
        test_reset();
        test_basic();
        test_phase_wrap();
        test_fractional();
        test_backpressure();
        test_ignored_starts();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
